// File: rtl/idec_pkg.sv
// Shared decoder constants: default widths, FSM state encoding and the
// position of the extension flag inside a buffered entry.
package idec_pkg;

    localparam int IW_DEF  = 16;
    localparam int OPW_DEF = 8;

    // Entry layout: {opcode, operand, is_ext}; the flag sits at the LSB.
    localparam int EXT_POS = 0;

    typedef enum logic {
        S_OP  = 1'b0,
        S_EXT = 1'b1
    } state_t;

endpackage

// File: rtl/idec_fifo2.sv
// Two-entry in-order buffer; a push shows at head the next cycle.
// Push is ignored when full and pop when empty; flush empties it.
module idec_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_dat,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign do_push = push && (count_q != 2'd2);
    assign do_pop  = pop && (count_q != 2'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push && !flush) mem_q[wr_ptr_q] <= push_dat;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/idec_pipe.sv
// Instruction decoder: splits words into opcode/operand, merging two-word forms;
// one cycle to out_valid, in_ready = buffer not full (registered, no out_ready path).
module idec_pipe
    import idec_pkg::*;
#(
    parameter int IW  = IW_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IW-1:0]  code_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] code_addr,
    output logic [IW-1:0]  data_addr,
    output logic           is_ext
);

    localparam int AW = IW - OPW;
    localparam int EW = OPW + IW + 1;

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [1:0]     count;
    logic [EW-1:0]  push_dat, head;
    logic           accept, push, pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_OP;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_OP;
        end else if (accept) begin
            if (state_q == S_OP) begin
                if (code_in[IW-1]) state_d = S_EXT;
            end else begin
                state_d = S_OP;
            end
        end
    end

    // Opcodes with the MSB set carry no operand; the next word supplies it whole.
    always_comb begin
        push     = 1'b0;
        push_dat = '0;
        op_d     = op_q;
        if (accept) begin
            if (state_q == S_OP) begin
                if (code_in[IW-1]) begin
                    op_d = code_in[IW-1:AW];
                end else begin
                    push                           = 1'b1;
                    push_dat[EXT_POS]              = 1'b0;
                    push_dat[EXT_POS+1 +: IW]      = {{OPW{1'b0}}, code_in[AW-1:0]};
                    push_dat[EXT_POS+1+IW +: OPW]  = code_in[IW-1:AW];
                end
            end else begin
                push                           = 1'b1;
                push_dat[EXT_POS]              = 1'b1;
                push_dat[EXT_POS+1 +: IW]      = code_in;
                push_dat[EXT_POS+1+IW +: OPW]  = op_q;
            end
        end
    end

    idec_fifo2 #(.W(EW)) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .flush    (flush),
        .push     (push),
        .pop      (pop),
        .push_dat (push_dat),
        .count    (count),
        .head     (head)
    );

    assign is_ext    = head[EXT_POS];
    assign data_addr = head[EXT_POS+1 +: IW];
    assign code_addr = head[EXT_POS+1+IW +: OPW];

endmodule

// File: tb/tb_idec_pipe.sv
// Self-checking bench for idec_pipe (IW=16, OPW=8) with a queue scoreboard.
module tb_idec_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid, is_ext;
    logic [15:0] code_in, data_addr;
    logic [7:0]  code_addr;

    int n_chk   = 0;
    int n_fail  = 0;
    int pop_cnt = 0;
    int snap;
    int mon_sz;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] d;
        logic        e;
    } ent_t;

    ent_t       sb[$];
    ent_t       mon_e;
    logic       m_ext = 1'b0;
    logic [7:0] m_op  = 8'h00;

    always #5 clk = ~clk;

    idec_pipe #(.IW(16), .OPW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code_in   (code_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code_addr (code_addr),
        .data_addr (data_addr),
        .is_ext    (is_ext)
    );

    // Reference model: tracks accepted words, predicts entries, checks head each cycle.
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            m_ext = 1'b0;
            m_op  = 8'h00;
        end else begin
            mon_sz = sb.size();
            n_chk++;
            if (out_valid !== (mon_sz != 0)) begin
                n_fail++;
                $display("FAIL sb_out_valid: got %b want %b", out_valid, (mon_sz != 0));
            end
            n_chk++;
            if (in_ready !== (mon_sz < 2)) begin
                n_fail++;
                $display("FAIL sb_in_ready: got %b want %b", in_ready, (mon_sz < 2));
            end
            if (mon_sz != 0) begin
                n_chk++;
                if ({code_addr, data_addr, is_ext} !== {sb[0].op, sb[0].d, sb[0].e}) begin
                    n_fail++;
                    $display("FAIL sb_head: got op=%h d=%h e=%b want op=%h d=%h e=%b",
                             code_addr, data_addr, is_ext, sb[0].op, sb[0].d, sb[0].e);
                end
                if (out_ready && !flush) begin
                    void'(sb.pop_front());
                    pop_cnt++;
                end
            end
            if (flush) begin
                sb.delete();
                m_ext = 1'b0;
            end else if (in_valid && mon_sz < 2) begin
                if (m_ext) begin
                    mon_e.op = m_op;
                    mon_e.d  = code_in;
                    mon_e.e  = 1'b1;
                    sb.push_back(mon_e);
                    m_ext = 1'b0;
                end else if (code_in[15]) begin
                    m_op  = code_in[15:8];
                    m_ext = 1'b1;
                end else begin
                    mon_e.op = code_in[15:8];
                    mon_e.d  = {8'h00, code_in[7:0]};
                    mon_e.e  = 1'b0;
                    sb.push_back(mon_e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        cyc(1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc(4);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; code_in = '0;
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || code_addr !== 8'h00 ||
            data_addr !== 16'h0000 || is_ext !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%b ir=%b op=%h d=%h e=%b want 0 1 00 0000 0",
                     out_valid, in_ready, code_addr, data_addr, is_ext);
        end
        // Release after an edge; the very next edge must accept a word.
        cyc(1);
        reset = 1'b1; in_valid = 1'b1; code_in = 16'h0042;
        cyc(1);
        in_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || code_addr !== 8'h00 || data_addr !== 16'h0042) begin
            n_fail++;
            $display("FAIL reset_release: got ov=%b op=%h d=%h want 1 00 0042",
                     out_valid, code_addr, data_addr);
        end
        drain();
    endtask

    task automatic test_single();
        cyc(1);
        out_ready = 1'b1; in_valid = 1'b1; code_in = 16'h1234;
        cyc(1);
        in_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || code_addr !== 8'h12 || data_addr !== 16'h0034 || is_ext !== 1'b0) begin
            n_fail++;
            $display("FAIL single: got ov=%b op=%h d=%h e=%b want 1 12 0034 0",
                     out_valid, code_addr, data_addr, is_ext);
        end
        drain();
    endtask

    task automatic test_ext();
        snap = pop_cnt;
        cyc(1);
        out_ready = 1'b1; in_valid = 1'b1; code_in = 16'h85AA;
        cyc(1);
        code_in = 16'hBEEF;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ext_first_word: got out_valid=%b want 0", out_valid);
        end
        cyc(1);
        in_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || code_addr !== 8'h85 || data_addr !== 16'hBEEF || is_ext !== 1'b1) begin
            n_fail++;
            $display("FAIL ext_entry: got ov=%b op=%h d=%h e=%b want 1 85 beef 1",
                     out_valid, code_addr, data_addr, is_ext);
        end
        cyc(3);
        n_chk++;
        if (pop_cnt - snap !== 1) begin
            n_fail++;
            $display("FAIL ext_count: got %0d entries want 1", pop_cnt - snap);
        end
        drain();
    endtask

    task automatic test_backpressure();
        bit accepted = 1'b0;
        int budget = 10;
        cyc(1);
        out_ready = 1'b0; in_valid = 1'b1; code_in = 16'h0101;
        cyc(1);
        code_in = 16'h0202;
        cyc(1);
        code_in = 16'h0303;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: got in_ready=%b want 0", in_ready);
        end
        cyc(3);
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || code_addr !== 8'h01) begin
            n_fail++;
            $display("FAIL bp_hold: got ir=%b ov=%b op=%h want 0 1 01", in_ready, out_valid, code_addr);
        end
        snap = pop_cnt;
        cyc(1);
        out_ready = 1'b1;
        while (!accepted && budget > 0) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            cyc(1);
            budget--;
        end
        in_valid = 1'b0;
        n_chk++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL bp_accept_timeout: got no accept of 0303 want accept within 10 cycles");
        end
        cyc(4);
        n_chk++;
        if (pop_cnt - snap !== 3) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d entries want 3", pop_cnt - snap);
        end
        drain();
    endtask

    task automatic test_flush();
        snap = pop_cnt;
        cyc(1);
        out_ready = 1'b1; in_valid = 1'b1; code_in = 16'h85AA;
        cyc(1);
        flush = 1'b1; code_in = 16'h3333;
        cyc(1);
        flush = 1'b0; in_valid = 1'b0;
        cyc(3);
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || pop_cnt !== snap) begin
            n_fail++;
            $display("FAIL flush_latched: got ov=%b entries=%0d want 0 0", out_valid, pop_cnt - snap);
        end
        cyc(1);
        in_valid = 1'b1; code_in = 16'h0101;
        cyc(1);
        in_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || code_addr !== 8'h01 || data_addr !== 16'h0001 || is_ext !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after: got ov=%b op=%h d=%h e=%b want 1 01 0001 0",
                     out_valid, code_addr, data_addr, is_ext);
        end
        drain();
        // Flushing a buffered entry discards it.
        out_ready = 1'b0; in_valid = 1'b1; code_in = 16'h0505;
        cyc(1);
        in_valid = 1'b0; flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_buffer: got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        cyc(1);
        out_ready = 1'b0; in_valid = 1'b1; code_in = 16'h0042;
        cyc(1);
        out_ready = 1'b1; code_in = 16'h1000;
        snap = pop_cnt;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_cycle%0d: got ov=%b ir=%b want 1 1", i, out_valid, in_ready);
            end
            cyc(1);
            if (i < 7) code_in = code_in + 16'd1;
            else in_valid = 1'b0;
        end
        n_chk++;
        if (pop_cnt - snap !== 8) begin
            n_fail++;
            $display("FAIL stream_rate: got %0d entries in 8 cycles want 8", pop_cnt - snap);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        cyc(1);
        out_ready = 1'b0; in_valid = 1'b1; code_in = 16'h0707;
        cyc(1);
        code_in = 16'h0808;
        cyc(1);
        in_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_full: got ir=%b ov=%b want 0 1", in_ready, out_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || code_addr !== 8'h00 ||
            data_addr !== 16'h0000 || is_ext !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got ov=%b ir=%b op=%h d=%h e=%b want 0 1 00 0000 0",
                     out_valid, in_ready, code_addr, data_addr, is_ext);
        end
        cyc(2);
        reset = 1'b1; out_ready = 1'b1;
        snap = pop_cnt;
        cyc(4);
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || pop_cnt !== snap) begin
            n_fail++;
            $display("FAIL rst_mid_stale: got ov=%b entries=%0d want 0 0", out_valid, pop_cnt - snap);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ext();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/idec_pipe.md
IDEC_PIPE -- requirements
Module: idec_pipe

Interface
REQ-001 Parameter IW, default 16, instruction word width in bits; SHALL be >= 8.
REQ-002 Parameter OPW, default 8, opcode field width; SHALL satisfy 2 <= OPW < IW; operand width AW = IW-OPW.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port flush  input  1  synchronous pipeline clear.
REQ-006 Port in_valid  input  1  code_in carries a valid word.
REQ-007 Port in_ready  output  1  block accepts code_in this cycle.
REQ-008 Port code_in  input  IW  instruction word.
REQ-009 Port out_valid  output  1  decoded entry available.
REQ-010 Port out_ready  input  1  consumer takes the entry this cycle.
REQ-011 Port code_addr  output  OPW  decoded opcode.
REQ-012 Port data_addr  output  IW  decoded operand, zero-extended.
REQ-013 Port is_ext  output  1  entry came from a two-word instruction.

Function
REQ-014 Word transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; output transfer only on a cycle with out_valid=1 and out_ready=1.
REQ-015 Field split: opcode = code_in[IW-1:AW]; operand = code_in[AW-1:0].
REQ-016 FSM states: S_OP (awaiting opcode word) and S_EXT (awaiting extension word).
REQ-017 In S_OP, if opcode MSB = 0, the block SHALL push {opcode, zero-extended operand, is_ext=0} and remain in S_OP.
REQ-018 In S_OP, if opcode MSB = 1, the block SHALL latch the opcode, discard the operand bits, push nothing, and move to S_EXT.
REQ-019 In S_EXT, the next accepted word SHALL be taken whole as operand; the block SHALL push {latched opcode, word, is_ext=1} and return to S_OP.
REQ-020 Decoded entries SHALL pass through a 2-entry in-order buffer; out_valid = (count != 0); outputs show the head entry.
REQ-021 in_ready SHALL be (count < 2), driven from registers only, with no combinational path from out_ready.
REQ-022 Latency: a pushing transfer in cycle N with an empty buffer SHALL yield out_valid=1 in cycle N+1.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and sustain one entry per cycle.
REQ-024 While out_valid=1 and out_ready=0, code_addr, data_addr and is_ext SHALL hold stable.
REQ-025 flush=1 SHALL, at the next edge, set count to 0 and the FSM to S_OP; any word presented that cycle SHALL be dropped; flush overrides push and pop.
REQ-026 A latched opcode lost to flush or reset SHALL produce no output.

Reset
REQ-027 reset low SHALL immediately force count=0, FSM=S_OP, out_valid=0, code_addr=0, data_addr=0, is_ext=0, latched opcode=0.
REQ-028 in_ready SHALL read 1 during and after reset (count=0).
REQ-029 Reset deassertion SHALL take effect at the first clk edge after reset rises, with no extra idle cycle.

Structure
REQ-030 Package idec_pkg SHALL hold the default IW and OPW, the FSM state typedef (S_OP, S_EXT), and the extension-flag position constant.
REQ-031 The 2-entry buffer SHALL be a sub-module idec_fifo2, parametrised on entry width, with push, pop, flush, count and head ports.

Verification (IW=16, OPW=8)
REQ-032 Push 0x1234 with out_ready=1 -> next cycle out_valid=1, code_addr=0x12, data_addr=0x0034, is_ext=0.
REQ-033 Push 0x85AA then 0xBEEF -> exactly one entry: code_addr=0x85, data_addr=0xBEEF, is_ext=1; no out_valid after the first word.
REQ-034 out_ready=0; push 0x0101, 0x0202, 0x0303 -> in_ready=0 after 2 accepts; 0x0303 held; release drains 0x01, 0x02, 0x03 in order.
REQ-035 Push 0x85AA, then flush=1 -> no output; next push of 0x0101 -> code_addr=0x01, data_addr=0x0001, is_ext=0.
REQ-036 Buffer at count=1 with continuous push and pop of 0x1000..0x1007 -> 8 entries in 8 consecutive cycles, count stays 1.
REQ-037 reset low mid-stream with 2 entries buffered -> out_valid=0 and all outputs 0 immediately; no stale entry after release.
